// File: rtl/fila_movimentos.sv
// fila_movimentos
// Holds the solver's movement list as it arrives from the serial receiver and
// presents the movements one at a time to the servo movement executor.
// The list is a stream of byte codes 0x01..0x06 ended by a 0x00 terminator.
//
// Ports:
//   clock          system clock, all state changes on its rising edge
//   reset          asynchronous active-low reset
//   limpar         synchronous clear from the control unit
//   habilitar_rx   high during the movement phase; bytes accepted only then
//   rx_pronto      one-cycle strobe qualifying rx_dado
//   rx_dado        received byte
//   mov_valido     queue head holds a movement
//   mov_codigo     movement code at the queue head (show-ahead)
//   mov_aceito     executor consumes the head this cycle
//   lista_completa terminator received, held until the block returns idle
//   fim_movimentos one-cycle pulse once the list is complete and drained
//   erro           sticky flag: overflow or invalid code
//   db_contagem    current occupancy
module fila_movimentos #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              limpar,
    input  logic              habilitar_rx,
    input  logic              rx_pronto,
    input  logic [7:0]        rx_dado,
    output logic              mov_valido,
    output logic [2:0]        mov_codigo,
    input  logic              mov_aceito,
    output logic              lista_completa,
    output logic              fim_movimentos,
    output logic              erro,
    output logic [ADDR_W:0]   db_contagem
);

    localparam logic [1:0] OCIOSO    = 2'd0;
    localparam logic [1:0] RECEBENDO = 2'd1;
    localparam logic [1:0] DRENANDO  = 2'd2;
    localparam logic [1:0] FIM       = 2'd3;

    localparam logic [ADDR_W:0] CHEIO = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        estado_q, estado_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              erro_q, erro_d;

    logic [2:0]        mem [DEPTH];

    logic byte_ok;
    logic cod_valido;
    logic terminador;
    logic cheio;
    logic pop_en;
    logic push_en;

    always_comb begin
        byte_ok    = (estado_q == RECEBENDO) && habilitar_rx && rx_pronto;
        cod_valido = (rx_dado >= 8'd1) && (rx_dado <= 8'd6);
        terminador = (rx_dado == 8'd0);
        cheio      = (count_q == CHEIO);
        pop_en     = !limpar && mov_aceito && (count_q != '0);
        // A full queue still takes a byte when the head leaves in the same cycle.
        push_en    = !limpar && byte_ok && cod_valido && (!cheio || pop_en);

        estado_d = estado_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        erro_d   = erro_q;

        if (limpar) begin
            estado_d = OCIOSO;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            erro_d   = 1'b0;
        end else begin
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (push_en && !pop_en) begin
                count_d = count_q + 1'b1;
            end else if (pop_en && !push_en) begin
                count_d = count_q - 1'b1;
            end

            if (byte_ok && !cod_valido && !terminador) begin
                erro_d = 1'b1;
            end
            if (byte_ok && cod_valido && cheio && !pop_en) begin
                erro_d = 1'b1;
            end

            case (estado_q)
                OCIOSO: begin
                    if (habilitar_rx) begin
                        estado_d = RECEBENDO;
                    end
                end
                RECEBENDO: begin
                    if (byte_ok && terminador) begin
                        estado_d = DRENANDO;
                    end
                end
                // Uses the registered occupancy, so FIM follows one cycle
                // after the last pop has emptied the queue.
                DRENANDO: begin
                    if (count_q == '0) begin
                        estado_d = FIM;
                    end
                end
                default: begin
                    estado_d = OCIOSO;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= OCIOSO;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            erro_q   <= erro_d;
        end
    end

    // Storage carries no reset; stale entries are hidden by mov_valido.
    always_ff @(posedge clock) begin
        if (push_en) begin
            mem[wr_ptr_q] <= rx_dado[2:0];
        end
    end

    assign mov_valido     = (count_q != '0);
    assign mov_codigo     = mov_valido ? mem[rd_ptr_q] : 3'd0;
    assign lista_completa = (estado_q == DRENANDO) || (estado_q == FIM);
    assign fim_movimentos = (estado_q == FIM);
    assign erro           = erro_q;
    assign db_contagem    = count_q;

endmodule

// File: tb/tb_fila_movimentos.sv
module tb_fila_movimentos;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    localparam int PH_IDLE  = 0;
    localparam int PH_RX    = 1;
    localparam int PH_DRAIN = 2;
    localparam int PH_DONE  = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              limpar = 1'b0;
    logic              habilitar_rx = 1'b0;
    logic              rx_pronto = 1'b0;
    logic [7:0]        rx_dado = 8'd0;
    logic              mov_aceito = 1'b0;
    logic              mov_valido;
    logic [2:0]        mov_codigo;
    logic              lista_completa;
    logic              fim_movimentos;
    logic              erro;
    logic [ADDR_W:0]   db_contagem;

    fila_movimentos #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .limpar         (limpar),
        .habilitar_rx   (habilitar_rx),
        .rx_pronto      (rx_pronto),
        .rx_dado        (rx_dado),
        .mov_valido     (mov_valido),
        .mov_codigo     (mov_codigo),
        .mov_aceito     (mov_aceito),
        .lista_completa (lista_completa),
        .fim_movimentos (fim_movimentos),
        .erro           (erro),
        .db_contagem    (db_contagem)
    );

    always #10 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: a plain queue of codes plus a phase and an error bit.
    int q[$];
    int m_phase = PH_IDLE;
    bit m_err   = 1'b0;

    // Observation log, written only by the monitor process.
    int cap[$];
    int fim_pulses = 0;

    task automatic model_step();
        int  sz;
        bit  pop;
        bit  push;
        bit  byte_ok;
        bit  code_ok;
        int  next_phase;
        if (!reset || limpar) begin
            q.delete();
            m_err   = 1'b0;
            m_phase = PH_IDLE;
            return;
        end
        sz      = q.size();
        pop     = mov_aceito && (sz > 0);
        byte_ok = (m_phase == PH_RX) && habilitar_rx && rx_pronto;
        code_ok = (rx_dado >= 8'd1) && (rx_dado <= 8'd6);
        push    = 1'b0;
        if (byte_ok && rx_dado > 8'd6) m_err = 1'b1;
        if (byte_ok && code_ok) begin
            if (sz < DEPTH || pop) push = 1'b1;
            else m_err = 1'b1;
        end
        next_phase = m_phase;
        case (m_phase)
            PH_IDLE:  if (habilitar_rx) next_phase = PH_RX;
            PH_RX:    if (byte_ok && rx_dado == 8'd0) next_phase = PH_DRAIN;
            PH_DRAIN: if (sz == 0) next_phase = PH_DONE;
            default:  next_phase = PH_IDLE;
        endcase
        m_phase = next_phase;
        if (pop) void'(q.pop_front());
        if (push) q.push_back(int'(rx_dado[2:0]));
    endtask

    always @(posedge clock) begin
        if (reset && !limpar && mov_aceito && mov_valido) cap.push_back(int'(mov_codigo));
        model_step();
        #2;
        check("valido", int'(mov_valido), int'(q.size() != 0));
        check("codigo", int'(mov_codigo), (q.size() != 0) ? q[0] : 0);
        check("lista", int'(lista_completa), int'(m_phase == PH_DRAIN || m_phase == PH_DONE));
        check("fim", int'(fim_movimentos), int'(m_phase == PH_DONE));
        check("erro", int'(erro), int'(m_err));
        check("contagem", int'(db_contagem), q.size());
        if (fim_movimentos) fim_pulses++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clock);
        rx_pronto = 1'b1;
        rx_dado   = b;
    endtask

    task automatic idle_rx();
        @(negedge clock);
        rx_pronto = 1'b0;
    endtask

    task automatic pulse_limpar();
        @(negedge clock);
        limpar = 1'b1;
        @(negedge clock);
        limpar = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valido"}, int'(mov_valido), 0);
        check({tag, "_codigo"}, int'(mov_codigo), 0);
        check({tag, "_lista"}, int'(lista_completa), 0);
        check({tag, "_fim"}, int'(fim_movimentos), 0);
        check({tag, "_erro"}, int'(erro), 0);
        check({tag, "_contagem"}, int'(db_contagem), 0);
    endtask

    initial begin
        int c0;
        int f0;
        int fours;

        // Power-up reset
        tick(3);
        #1 check_all_zero("reset");
        @(negedge clock);
        reset = 1'b1;
        tick(2);

        // List 01 02 03 00 with the executor always ready
        c0 = cap.size(); f0 = fim_pulses;
        mov_aceito = 1'b1; habilitar_rx = 1'b1;
        tick(1);
        send(8'h01); send(8'h02); send(8'h03); send(8'h00);
        idle_rx();
        tick(6);
        check("t1_npops", cap.size() - c0, 3);
        check("t1_pop0", cap[c0], 1);
        check("t1_pop1", cap[c0+1], 2);
        check("t1_pop2", cap[c0+2], 3);
        check("t1_fim_pulses", fim_pulses - f0, 1);
        check("t1_erro", int'(erro), 0);
        habilitar_rx = 1'b0;
        tick(2);

        // Empty list: terminator only
        c0 = cap.size(); f0 = fim_pulses;
        habilitar_rx = 1'b1;
        tick(1);
        send(8'h00);
        idle_rx();
        #1 check("t2_lista", int'(lista_completa), 1);
        check("t2_valido", int'(mov_valido), 0);
        tick(5);
        check("t2_npops", cap.size() - c0, 0);
        check("t2_fim_pulses", fim_pulses - f0, 1);
        habilitar_rx = 1'b0;
        pulse_limpar();

        // Overflow: DEPTH+1 codes with no pops
        c0 = cap.size(); f0 = fim_pulses;
        mov_aceito = 1'b0; habilitar_rx = 1'b1;
        tick(1);
        for (int i = 0; i < DEPTH + 1; i++) send(8'h04);
        idle_rx();
        #1 check("t3_contagem", int'(db_contagem), 32);
        check("t3_erro", int'(erro), 1);
        check("t3_head", int'(mov_codigo), 4);
        send(8'h00);
        idle_rx();
        mov_aceito = 1'b1;
        tick(40);
        check("t3_npops", cap.size() - c0, 32);
        fours = 0;
        for (int i = c0; i < cap.size(); i++) if (cap[i] == 4) fours++;
        check("t3_fours", fours, 32);
        check("t3_fim_pulses", fim_pulses - f0, 1);
        habilitar_rx = 1'b0;
        pulse_limpar();
        #1 check("t3_erro_cleared", int'(erro), 0);

        // Invalid code in the middle of a list
        c0 = cap.size(); f0 = fim_pulses;
        mov_aceito = 1'b0; habilitar_rx = 1'b1;
        tick(1);
        send(8'h05); send(8'h09);
        idle_rx();
        #1 check("t4_erro", int'(erro), 1);
        check("t4_contagem", int'(db_contagem), 1);
        send(8'h00);
        idle_rx();
        mov_aceito = 1'b1;
        tick(5);
        check("t4_npops", cap.size() - c0, 1);
        check("t4_pop0", cap[c0], 5);
        check("t4_fim_pulses", fim_pulses - f0, 1);
        habilitar_rx = 1'b0;
        pulse_limpar();

        // Simultaneous push and pop at count=1; bytes with habilitar_rx low
        mov_aceito = 1'b0; habilitar_rx = 1'b1;
        tick(1);
        send(8'h01);
        @(negedge clock);
        rx_dado = 8'h02; rx_pronto = 1'b1; mov_aceito = 1'b1;
        @(negedge clock);
        rx_pronto = 1'b0; mov_aceito = 1'b0;
        #1 check("t5_contagem", int'(db_contagem), 1);
        check("t5_head", int'(mov_codigo), 2);
        habilitar_rx = 1'b0;
        send(8'h03); send(8'h0A);
        idle_rx();
        #1 check("t5_ignored_cnt", int'(db_contagem), 1);
        check("t5_ignored_err", int'(erro), 0);
        habilitar_rx = 1'b1;
        f0 = fim_pulses;
        send(8'h00);
        idle_rx();
        mov_aceito = 1'b1;
        tick(5);
        check("t5_fim_pulses", fim_pulses - f0, 1);
        habilitar_rx = 1'b0;
        tick(2);

        // Asynchronous reset mid-list
        mov_aceito = 1'b0; habilitar_rx = 1'b1;
        tick(1);
        send(8'h01); send(8'h02); send(8'h03);
        idle_rx();
        #1 check("t6_pre_cnt", int'(db_contagem), 3);
        #3 reset = 1'b0; habilitar_rx = 1'b0;
        #1 check_all_zero("t6_async");
        tick(2);
        reset = 1'b1;
        // Byte arriving together with the enable rise is ignored
        @(negedge clock);
        habilitar_rx = 1'b1; rx_pronto = 1'b1; rx_dado = 8'h06;
        idle_rx();
        #1 check("t6_first_byte_ignored", int'(db_contagem), 0);
        c0 = cap.size(); f0 = fim_pulses;
        mov_aceito = 1'b1;
        send(8'h01); send(8'h00);
        idle_rx();
        tick(5);
        check("t6_npops", cap.size() - c0, 1);
        check("t6_pop0", cap[c0], 1);
        check("t6_fim_pulses", fim_pulses - f0, 1);
        habilitar_rx = 1'b0;
        tick(2);

        // Same sequence with limpar, including a byte in the clear cycle
        mov_aceito = 1'b0; habilitar_rx = 1'b1;
        tick(1);
        send(8'h01); send(8'h02); send(8'h09);
        idle_rx();
        #1 check("t7_pre_cnt", int'(db_contagem), 2);
        check("t7_pre_err", int'(erro), 1);
        @(negedge clock);
        limpar = 1'b1; rx_pronto = 1'b1; rx_dado = 8'h05;
        @(negedge clock);
        limpar = 1'b0; rx_pronto = 1'b0;
        #1 check_all_zero("t7_limpar");
        c0 = cap.size(); f0 = fim_pulses;
        mov_aceito = 1'b1;
        tick(1);
        send(8'h01); send(8'h00);
        idle_rx();
        tick(5);
        check("t7_npops", cap.size() - c0, 1);
        check("t7_pop0", cap[c0], 1);
        check("t7_fim_pulses", fim_pulses - f0, 1);
        habilitar_rx = 1'b0;
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
